fifo_read_prefetch: RTL and testbench

// - Read-side consumer for the FIFO pointer block. It drives rdreq from empty, absorbs the fixed RAM read latency, and presents entries downstream as a valid/ready stream.
// - Sits between a FifoPtrs + RAM pair and the downstream pipeline.
// - Sustains 1 entry/cycle with no dependence of downstream ready on rdreq timing.

---
 rtl/fifo_read_prefetch.sv | 112 +++++++++++
 tb/tb_fifo_read_prefetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_prefetch.sv
// Read-side prefetcher: pops a latency-L source FIFO/RAM and presents entries as a valid/ready stream.
// Optional protocol checker enabled by defining FIFO_READ_PREFETCH_CHECK_EN.
module fifo_read_prefetch #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             empty_in,
    output logic             rdreq_out,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] data_out,
    output logic             error_out
);

    localparam int unsigned SKID_DEPTH = READ_LATENCY + 1;
    localparam int unsigned CNT_W      = $clog2(SKID_DEPTH + 1);
    localparam int unsigned PTR_W      = ($clog2(SKID_DEPTH) > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned SUM_W      = CNT_W + 1;

    logic [READ_LATENCY-1:0] inflight_sr;
    logic [CNT_W-1:0]        inflight_cnt;
    logic [CNT_W-1:0]        occ;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [WIDTH-1:0]        mem [SKID_DEPTH];

    logic             land;
    logic             pop;
    logic             wr_en;
    logic             full;
    logic [SUM_W-1:0] credit_sum;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign land      = inflight_sr[READ_LATENCY-1];
    assign valid_out = (occ != '0);
    assign pop       = valid_out && ready_in;
    assign full      = (occ == CNT_W'(SKID_DEPTH));
    assign wr_en     = land && (!full || pop);
    assign data_out  = valid_out ? mem[rd_ptr] : '0;

    // Outstanding requests plus buffered entries, crediting a same-cycle pop
    assign credit_sum = SUM_W'(inflight_cnt) + SUM_W'(occ) - SUM_W'(pop);
    assign rdreq_out  = !empty_in && !rst && (credit_sum < SUM_W'(SKID_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_sr  <= '0;
            inflight_cnt <= '0;
            occ          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            inflight_sr  <= (inflight_sr << 1) | READ_LATENCY'(rdreq_out);
            inflight_cnt <= inflight_cnt + CNT_W'(rdreq_out) - CNT_W'(land);
            occ          <= occ + CNT_W'(wr_en) - CNT_W'(pop);
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

`ifdef FIFO_READ_PREFETCH_CHECK_EN
    logic valid_q;
    logic ready_q;
    logic err_rdreq;
    logic err_overflow;
    logic err_drop;

    assign err_rdreq    = rdreq_out && empty_in;
    assign err_overflow = land && full && !pop;
    assign err_drop     = valid_q && !valid_out && !ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            error_out <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            error_out <= error_out || err_rdreq || err_overflow || err_drop;
            valid_q   <= valid_out;
            ready_q   <= ready_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!err_rdreq);
            assert (!err_overflow);
            assert (!err_drop);
        end
    end
`else
    assign error_out = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_read_prefetch.sv
// Directed bench for fifo_read_prefetch with a latency-accurate source FIFO model.
module tb_fifo_read_prefetch;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned RL    = 2;
    localparam int unsigned DEPTH = RL + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             empty_in;
    logic             rdreq_out;
    logic [WIDTH-1:0] data_in;
    logic             valid_out;
    logic             ready_in;
    logic [WIDTH-1:0] data_out;
    logic             error_out;

    fifo_read_prefetch #(.WIDTH(WIDTH), .READ_LATENCY(RL)) dut (
        .clk       (clk),
        .rst       (rst),
        .empty_in  (empty_in),
        .rdreq_out (rdreq_out),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .error_out (error_out)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_rq     = 0;
    int n_rx     = 0;

    logic [WIDTH-1:0] src_q [$];
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] pipe [RL];
    logic             src_stall = 1'b0;
    logic             snk_ready = 1'b1;
    logic             rand_mode = 1'b0;
    int               es_cnt = 0;
    int               rs_cnt = 0;
    logic             s_rdreq, s_valid;
    logic [WIDTH-1:0] s_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at negedge, sample before posedge, advance source model after it
    task automatic cycle();
        logic [WIDTH-1:0] v;
        @(negedge clk);
        if (rand_mode) begin
            if (es_cnt > 0) es_cnt--;
            else if ($urandom_range(0, 3) == 0) es_cnt = $urandom_range(1, 10);
            if (rs_cnt > 0) rs_cnt--;
            else if ($urandom_range(0, 3) == 0) rs_cnt = $urandom_range(1, 10);
            src_stall = (es_cnt != 0);
            snk_ready = (rs_cnt == 0);
        end
        empty_in = (src_q.size() == 0) || src_stall;
        ready_in = snk_ready;
        #1;
        s_rdreq = rdreq_out;
        s_valid = valid_out;
        s_data  = data_out;
        if (s_rdreq) chk("rdreq_while_empty", 32'(empty_in), 32'd0);
        if (s_valid && ready_in) begin
            if (exp_q.size() == 0) chk("spurious_transfer", 32'd1, 32'd0);
            else chk("transfer_data", s_data, exp_q.pop_front());
            n_rx++;
        end
        @(posedge clk);
        #1;
        v = 32'hDEAD_BEEF;
        if (s_rdreq && src_q.size() != 0) begin
            v = src_q.pop_front();
            exp_q.push_back(v);
            n_rq++;
        end
        for (int i = RL - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = v;
        data_in = pipe[RL-1];
    endtask

    initial begin
        int base_rq, base_rx, cyc;
        rst      = 1'b1;
        empty_in = 1'b1;
        ready_in = 1'b1;
        data_in  = 32'hDEAD_BEEF;
        for (int i = 0; i < RL; i++) pipe[i] = 32'hDEAD_BEEF;

        // Reset held 50 cycles, then idle with an empty source
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (i % 10 == 9) begin
                chk("rst_rdreq", 32'(s_rdreq), 32'd0);
                chk("rst_valid", 32'(s_valid), 32'd0);
                chk("rst_data", s_data, 32'd0);
                chk("rst_error", 32'(error_out), 32'd0);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("idle_rdreq", 32'(s_rdreq), 32'd0);
            chk("idle_valid", 32'(s_valid), 32'd0);
        end

        // First-word latency: request at cycle 0, visible at cycle 3 only
        src_q.push_back(32'hA5);
        for (int c = 0; c < 6; c++) begin
            cycle();
            chk("lat_rdreq", 32'(s_rdreq), 32'(c == 0));
            chk("lat_valid", 32'(s_valid), 32'(c == 3));
            if (c == 3) chk("lat_data", s_data, 32'hA5);
        end

        // Throughput: 1000 entries in 1000 + RL + 1 cycles
        for (int i = 0; i < 1000; i++) src_q.push_back(32'(i));
        base_rq = n_rq;
        base_rx = n_rx;
        for (int c = 0; c < 1000 + RL + 1; c++) begin
            cycle();
            if (c == 999) chk("tp_rdreq_count", 32'(n_rq - base_rq), 32'd1000);
        end
        chk("tp_transfers", 32'(n_rx - base_rx), 32'd1000);
        chk("tp_exp_empty", 32'(exp_q.size()), 32'd0);
        cycle();
        chk("tp_valid_after", 32'(s_valid), 32'd0);

        // Backpressure: exactly DEPTH requests, then hold until released
        snk_ready = 1'b0;
        for (int i = 0; i < 8; i++) src_q.push_back(32'h100 + 32'(i));
        base_rq = n_rq;
        base_rx = n_rx;
        for (int c = 0; c < 10; c++) cycle();
        chk("bp_rdreq_count", 32'(n_rq - base_rq), 32'(DEPTH));
        chk("bp_rdreq_low", 32'(s_rdreq), 32'd0);
        chk("bp_valid_held", 32'(s_valid), 32'd1);
        chk("bp_data_head", s_data, 32'h100);
        snk_ready = 1'b1;
        for (int c = 0; c < DEPTH; c++) cycle();
        chk("bp_release_three", 32'(n_rx - base_rx), 32'(DEPTH));
        for (int c = 0; c < 15; c++) cycle();
        chk("bp_all_drained", 32'(n_rx - base_rx), 32'd8);
        chk("bp_error", 32'(error_out), 32'd0);

        // Random stalls on both sides, two seeds
        for (int seed = 1; seed <= 2; seed++) begin
            void'($urandom(seed));
            for (int i = 0; i < 3000; i++) src_q.push_back(32'(seed * 32'h10000 + i));
            base_rx = n_rx;
            cyc = 0;
            rand_mode = 1'b1;
            while ((n_rx - base_rx) < 3000 && cyc < 40000) begin
                cycle();
                cyc++;
            end
            rand_mode = 1'b0;
            src_stall = 1'b0;
            snk_ready = 1'b1;
            es_cnt = 0;
            rs_cnt = 0;
            chk("rand_received", 32'(n_rx - base_rx), 32'd3000);
            chk("rand_exp_empty", 32'(exp_q.size()), 32'd0);
            chk("rand_error", 32'(error_out), 32'd0);
        end

        // Mid-operation reset with two reads in flight
        for (int i = 0; i < 5; i++) src_q.push_back(32'h200 + 32'(i));
        base_rx = n_rx;
        cycle();
        chk("mid_rdreq0", 32'(s_rdreq), 32'd1);
        cycle();
        chk("mid_rdreq1", 32'(s_rdreq), 32'd1);
        src_stall = 1'b1;
        rst = 1'b1;
        cycle();
        chk("mid_rdreq_rst", 32'(s_rdreq), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("mid_no_valid", 32'(s_valid), 32'd0);
        end
        src_stall = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        chk("mid_first_post_reset", s_data, 32'h202);
        for (int c = 0; c < 8; c++) cycle();
        chk("mid_received", 32'(n_rx - base_rx), 32'd3);
        chk("mid_error", 32'(error_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
